// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan driver: segment bit
// positions, the logical hex glyph table and the output polarity helper.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Logical lit-segment patterns (bit 0 = a .. bit 6 = g), entry 0 in the LSBs.
    localparam logic [16*7-1:0] HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [7:0] apply_pol(input logic [7:0] value, input logic active_low);
        return active_low ? ~value : value;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble plus decimal point to logical segment pattern
// (1 = segment lit); polarity is applied later at the output register.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    always_comb begin
        pattern                = '0;
        pattern[SEG_G:SEG_A]   = HEX_TABLE[7*nibble +: 7];
        pattern[SEG_DP]        = dp;
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with frame-synchronous shadow
// capture, dead time, PWM brightness, blank/blink and leading-zero suppression.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_TICKS     = 50000,
    parameter int DEAD_TICKS     = 500,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_en,
    input  logic [3:0]              bright,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic                    frame_done
);

    localparam int SLOT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic SEL_LOW = (SEL_ACTIVE_LOW != 0);

    logic [SLOT_W-1:0] slot_cnt;
    logic [DIG_W-1:0]  digit;
    logic [3:0]        pwm_cnt;
    logic [FRM_W-1:0]  frame_cnt;
    logic              blink_phase;
    logic              started;

    logic [4*NUM_DIGITS-1:0] sh_data;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic [NUM_DIGITS-1:0]   sh_lz_mask;
    logic                    sh_lz_en;
    logic [3:0]              sh_bright;

    logic slot_last;
    logic digit_last;
    logic frame_end;
    logic snap;

    assign slot_last  = (int'(slot_cnt) == SCAN_TICKS - 1);
    assign digit_last = (int'(digit) == NUM_DIGITS - 1);
    assign frame_end  = slot_last && digit_last;
    assign snap       = !started || frame_end;

    // Leading-zero mask of the live inputs, digit-indexed (bit i = digit i).
    logic [NUM_DIGITS-1:0] live_lz_mask;
    logic                  zero_run;

    always_comb begin
        zero_run     = 1'b1;
        live_lz_mask = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_run        = zero_run && (data_in[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
            live_lz_mask[i] = zero_run && (i < NUM_DIGITS - 1);
        end
    end

    // Until the first snapshot lands, decisions come straight from the inputs
    // being captured, so the very first slot already shows the new frame.
    logic [4*NUM_DIGITS-1:0] cur_data;
    logic [NUM_DIGITS-1:0]   cur_dp;
    logic [NUM_DIGITS-1:0]   cur_blank;
    logic [NUM_DIGITS-1:0]   cur_blink;
    logic [NUM_DIGITS-1:0]   cur_lz_mask;
    logic                    cur_lz_en;
    logic [3:0]              cur_bright;

    assign cur_data    = started ? sh_data    : data_in;
    assign cur_dp      = started ? sh_dp      : dp_in;
    assign cur_blank   = started ? sh_blank   : blank_in;
    assign cur_blink   = started ? sh_blink   : blink_in;
    assign cur_lz_mask = started ? sh_lz_mask : live_lz_mask;
    assign cur_lz_en   = started ? sh_lz_en   : lz_en;
    assign cur_bright  = started ? sh_bright  : bright;

    logic [3:0]            nib_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_d;
    logic [NUM_DIGITS-1:0] blank_d;
    logic [NUM_DIGITS-1:0] blink_d;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign nib_d[i]   = cur_data[4*(NUM_DIGITS-1-i) +: 4];
        assign dp_d[i]    = cur_dp[NUM_DIGITS-1-i];
        assign blank_d[i] = cur_blank[NUM_DIGITS-1-i];
        assign blink_d[i] = cur_blink[NUM_DIGITS-1-i];
    end

    logic [7:0] hex_pattern;

    seg_hex_decode u_hex_decode (
        .nibble  (nib_d[digit]),
        .dp      (dp_d[digit]),
        .pattern (hex_pattern)
    );

    logic                  blanked;
    logic                  suppressed;
    logic                  in_dead;
    logic                  pwm_on;
    logic [7:0]            seg_log;
    logic [NUM_DIGITS-1:0] sel_log;

    always_comb begin
        blanked    = blank_d[digit] || (blink_phase && blink_d[digit]);
        suppressed = cur_lz_en && cur_lz_mask[digit];
        in_dead    = (int'(slot_cnt) < DEAD_TICKS);
        pwm_on     = (cur_bright == 4'hF) || (pwm_cnt < cur_bright);
        seg_log    = hex_pattern;
        if (blanked) begin
            seg_log = '0;
        end else if (suppressed) begin
            seg_log         = '0;
            seg_log[SEG_DP] = dp_d[digit];
        end
        sel_log = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_log[i] = !blanked && !in_dead && pwm_on && (int'(digit) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            digit       <= '0;
            pwm_cnt     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            started     <= 1'b0;
        end else begin
            started <= 1'b1;
            pwm_cnt <= pwm_cnt + 4'd1;
            if (slot_last) begin
                slot_cnt <= '0;
                digit    <= digit_last ? '0 : digit + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            if (started && frame_end) begin
                if (int'(frame_cnt) == BLINK_FRAMES - 1) begin
                    frame_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_blink   <= '0;
            sh_lz_mask <= '0;
            sh_lz_en   <= 1'b0;
            sh_bright  <= '0;
        end else if (snap) begin
            sh_data    <= data_in;
            sh_dp      <= dp_in;
            sh_blank   <= blank_in;
            sh_blink   <= blink_in;
            sh_lz_mask <= live_lz_mask;
            sh_lz_en   <= lz_en;
            sh_bright  <= bright;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= apply_pol(8'h00, SEG_LOW);
            sel        <= SEL_LOW ? '1 : '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= apply_pol(seg_log, SEG_LOW);
            sel        <= SEL_LOW ? ~sel_log : sel_log;
            frame_done <= started && frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame-level reference model feeding an expected
// queue, checked cycle by cycle from one task per scenario.
module tb_seg_scan_driver;

    localparam int ND    = 4;
    localparam int ST    = 32;
    localparam int DT    = 4;
    localparam int BF    = 2;
    localparam int FRAME = ND * ST;
    localparam logic [6:0] HEX_REF [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   data_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic [3:0]    blink_in = '0;
    logic          lz_en = 1'b0;
    logic [3:0]    bright = '0;
    logic [7:0]    seg;
    logic [3:0]    sel;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;
    logic [12:0] exp_q[$];

    // model's view of the frame being displayed
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blank, m_blink, m_bright;
    logic        m_lz;

    seg_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_TICKS(ST), .DEAD_TICKS(DT), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .lz_en(lz_en), .bright(bright),
        .seg(seg), .sel(sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic void capture();
        m_data = data_in; m_dp = dp_in; m_blank = blank_in;
        m_blink = blink_in; m_lz = lz_en; m_bright = bright;
    endfunction

    // expected {frame_done, seg, sel} right after clock kk since reset release
    function automatic logic [12:0] model_out(int kk);
        int d, s, p, f;
        logic ph, blanked, supp, zero_prefix, on;
        logic [3:0] nib, sel_l;
        logic [7:0] lit;
        d = (kk / ST) % ND;
        s = kk % ST;
        p = kk % 16;
        f = kk / FRAME;
        ph = ((f / BF) % 2) == 1;
        nib = m_data[4*(ND-1-d) +: 4];
        blanked = m_blank[ND-1-d] || (ph && m_blink[ND-1-d]);
        zero_prefix = 1'b1;
        for (int j = 0; j <= d; j++) if (m_data[4*(ND-1-j) +: 4] != 4'h0) zero_prefix = 1'b0;
        supp = m_lz && zero_prefix && (d < ND - 1);
        if (blanked) lit = 8'h00;
        else if (supp) lit = {m_dp[ND-1-d], 7'h00};
        else lit = {m_dp[ND-1-d], HEX_REF[nib]};
        on = !blanked && (s >= DT) && (m_bright == 4'hF || p < int'(m_bright));
        sel_l = 4'hF;
        if (on) sel_l[d] = 1'b0;
        return {(kk % FRAME) == FRAME - 1, ~lit, sel_l};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            exp_q.delete();
        end else begin
            if (k == 0) capture();
            exp_q.push_back(model_out(k));
            if ((k % FRAME) == FRAME - 1) capture();
            k++;
        end
    end

    task automatic release_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h required ff", seg); end
        n_checks++; if (sel !== 4'hF) begin n_fail++; $display("FAIL reset_sel: got %h required f", sel); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        data_in = 16'h12AF; bright = 4'hF;
        release_reset();
    endtask

    task automatic test_hex_scan();
        logic [12:0] exp;
        int pulses = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL hex_scan: no expected entry"); end
            else begin
                exp = exp_q.pop_front();
                if ({frame_done, seg, sel} !== exp) begin
                    n_fail++; $display("FAIL hex_scan k=%0d: got fd/seg/sel %h required %h", k, {frame_done, seg, sel}, exp);
                end
            end
            if (frame_done) pulses++;
        end
        n_checks++;
        if (pulses != 2) begin n_fail++; $display("FAIL hex_frame_done_count: got %0d required 2", pulses); end
    endtask

    task automatic test_lz();
        logic [12:0] exp;
        for (int ph = 0; ph < 2; ph++) begin
            data_in = (ph == 0) ? 16'h0050 : 16'h0000;
            lz_en = 1'b1;
            repeat (2 * FRAME) begin
                @(negedge clk);
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL lz: no expected entry"); end
                else begin
                    exp = exp_q.pop_front();
                    if ({frame_done, seg, sel} !== exp) begin
                        n_fail++; $display("FAIL lz data=%h k=%0d: got %h required %h", data_in, k, {frame_done, seg, sel}, exp);
                    end
                end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_brightness();
        logic [12:0] exp;
        logic [3:0] levels [4];
        int active;
        levels[0] = 4'd4; levels[1] = 4'd0; levels[2] = 4'($urandom_range(1, 14)); levels[3] = 4'hF;
        data_in = 16'($urandom);
        for (int l = 0; l < 4; l++) begin
            bright = levels[l];
            active = 0;
            repeat (2 * FRAME) begin
                @(negedge clk);
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL bright: no expected entry"); end
                else begin
                    exp = exp_q.pop_front();
                    if ({frame_done, seg, sel} !== exp) begin
                        n_fail++; $display("FAIL bright=%0d k=%0d: got %h required %h", bright, k, {frame_done, seg, sel}, exp);
                    end
                end
                if (sel != 4'hF) active++;
            end
            if (levels[l] == 4'd0) begin
                n_checks++;
                if (active > FRAME) begin n_fail++; $display("FAIL bright_zero_dark: got %0d active cycles required at most %0d", active, FRAME); end
            end
        end
    endtask

    task automatic test_no_tearing();
        logic [12:0] exp;
        int n = 0;
        data_in = 16'h1111; bright = 4'hF;
        repeat (3 * FRAME) begin
            @(negedge clk);
            n++;
            if (n == FRAME + 60) data_in = 16'h2222;
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL tearing: no expected entry"); end
            else begin
                exp = exp_q.pop_front();
                if ({frame_done, seg, sel} !== exp) begin
                    n_fail++; $display("FAIL tearing k=%0d: got %h required %h", k, {frame_done, seg, sel}, exp);
                end
            end
        end
    endtask

    task automatic test_blink_blank();
        logic [12:0] exp;
        data_in = 16'h8421; blink_in = 4'b0001;
        repeat (5 * FRAME) begin
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL blink: no expected entry"); end
            else begin
                exp = exp_q.pop_front();
                if ({frame_done, seg, sel} !== exp) begin
                    n_fail++; $display("FAIL blink k=%0d: got %h required %h", k, {frame_done, seg, sel}, exp);
                end
            end
        end
        blink_in = 4'b0000; blank_in = 4'b1000;
        repeat (2 * FRAME) begin
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL blank: no expected entry"); end
            else begin
                exp = exp_q.pop_front();
                if ({frame_done, seg, sel} !== exp) begin
                    n_fail++; $display("FAIL blank k=%0d: got %h required %h", k, {frame_done, seg, sel}, exp);
                end
            end
        end
        blank_in = 4'b0000;
    endtask

    task automatic test_reset_mid_scan();
        logic [12:0] exp;
        int guard = 0;
        data_in = 16'h3C5A; bright = 4'hF;
        while (!(((k / ST) % ND) == 2 && (k % ST) == 10) && guard < 4 * FRAME) begin
            @(negedge clk);
            guard++;
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL reset_mid_pre: no expected entry"); end
            else begin
                exp = exp_q.pop_front();
                if ({frame_done, seg, sel} !== exp) begin
                    n_fail++; $display("FAIL reset_mid_pre k=%0d: got %h required %h", k, {frame_done, seg, sel}, exp);
                end
            end
        end
        n_checks++;
        if (guard >= 4 * FRAME) begin n_fail++; $display("FAIL reset_mid_wait: digit 2 slot not reached in %0d cycles", guard); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({frame_done, seg, sel} !== {1'b0, 8'hFF, 4'hF}) begin
            n_fail++; $display("FAIL reset_mid_async: got %h required %h", {frame_done, seg, sel}, {1'b0, 8'hFF, 4'hF});
        end
        data_in = 16'h9E07;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * FRAME) begin
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL reset_mid_post: no expected entry"); end
            else begin
                exp = exp_q.pop_front();
                if ({frame_done, seg, sel} !== exp) begin
                    n_fail++; $display("FAIL reset_mid_post k=%0d: got %h required %h", k, {frame_done, seg, sel}, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [12:0] exp;
        repeat (6 * FRAME) begin
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL random: no expected entry"); end
            else begin
                exp = exp_q.pop_front();
                if ({frame_done, seg, sel} !== exp) begin
                    n_fail++; $display("FAIL random k=%0d: got %h required %h", k, {frame_done, seg, sel}, exp);
                end
            end
            n_checks++;
            if ($countones(~sel) > 1) begin n_fail++; $display("FAIL random_sel_onehot: got sel %b required at most one active", sel); end
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 5))
                    0: data_in  = 16'($urandom);
                    1: dp_in    = 4'($urandom);
                    2: blank_in = 4'($urandom) & 4'($urandom);
                    3: blink_in = 4'($urandom);
                    4: lz_en    = 1'($urandom);
                    default: bright = 4'($urandom_range(0, 15));
                endcase
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex_scan();
        test_lz();
        test_brightness();
        test_no_tearing();
        test_blink_blank();
        test_reset_mid_scan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
